reload_counter_p: RTL and testbench

Parametrised self-reloading counter, successor to the fixed 4-bit up-only self-reloading counter.
- Adds: configurable width, up/down direction, auto-reload or one-shot mode, programmable tick prescaler, count enable, terminal-count pulse and done flag.
- Sits in timer/event-generation paths: software loads a start value, the block counts and either reloads or halts at terminal count.

---
 rtl/reload_counter_pkg.sv | 14 +
 rtl/reload_prescaler.sv | 38 +++
 rtl/reload_counter_p.sv | 99 +++++++++
 tb/tb_reload_counter_p.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reload_counter_pkg.sv
// rtl/reload_counter_pkg.sv - shared types and encodings for the self-reloading counter
package reload_counter_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_AUTO    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/reload_prescaler.sv
// rtl/reload_prescaler.sv - tick divider, one tick_pre every prescale+1 enabled cycles
module reload_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick_pre
);

   logic [PRESCALE_W-1:0] pre_q;
   logic [PRESCALE_W-1:0] pre_d;

   // prescale is compared live, so a new divider applies at the next compare
   assign tick_pre = en && (pre_q == prescale);

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (tick_pre) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = pre_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/reload_counter_p.sv
// rtl/reload_counter_p.sv - up/down counter with auto-reload or one-shot halt at terminal count
module reload_counter_p
   import reload_counter_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [WIDTH-1:0]      load_val_i,
   input  logic                  en_i,
   input  logic                  dir_i,
   input  logic                  mode_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic [WIDTH-1:0]      count_o,
   output logic                  tc_o,
   output logic                  done_o,
   output logic                  running_o
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   logic             run;
   logic             tick_pre;
   logic             tick;
   logic             terminal;

   assign run = (state_q == RUN);

   // Prescaler only advances while counting, so HALT freezes it as well
   reload_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .clr      (load_i),
      .en       (en_i && run),
      .prescale (prescale_i),
      .tick_pre (tick_pre)
   );

   assign tick     = tick_pre && run;
   assign terminal = (dir_i == DIR_DOWN) ? (count_q == '0) : (count_q == '1);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = done_q;
      tc_d     = 1'b0;
      if (load_i) begin
         count_d  = load_val_i;
         reload_d = load_val_i;
         done_d   = 1'b0;
         state_d  = RUN;
      end else if (tick) begin
         if (terminal) begin
            tc_d = 1'b1;
            if (mode_i == MODE_ONESHOT) begin
               done_d  = 1'b1;
               state_d = HALT;
            end else begin
               count_d = reload_q;
            end
         end else if (dir_i == DIR_DOWN) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         done_q   <= done_d;
      end
   end

   assign count_o   = count_q;
   assign tc_o      = tc_q;
   assign done_o    = done_q;
   assign running_o = run;

endmodule

// File: tb/tb_reload_counter_p.sv
// tb/tb_reload_counter_p.sv - scoreboard bench for reload_counter_p
module tb_reload_counter_p;
   import reload_counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_i = 1'b0;
   logic [3:0] load_val_i = '0;
   logic       en_i = 1'b0;
   logic       dir_i = 1'b0;
   logic       mode_i = 1'b0;
   logic [3:0] prescale_i = '0;
   logic [3:0] count_o;
   logic       tc_o;
   logic       done_o;
   logic       running_o;

   typedef struct {
      logic [3:0] c;
      logic       tc;
      logic       dn;
      logic       rn;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   logic       d_dir = 1'b0;
   logic       d_mode = 1'b0;
   logic [3:0] d_pre = '0;

   reload_counter_p #(.WIDTH(4), .PRESCALE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .en_i       (en_i),
      .dir_i      (dir_i),
      .mode_i     (mode_i),
      .prescale_i (prescale_i),
      .count_o    (count_o),
      .tc_o       (tc_o),
      .done_o     (done_o),
      .running_o  (running_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endfunction

   // Drive one cycle of stimulus and queue the state expected after that edge
   task automatic cyc(input logic ld, input logic [3:0] v, input logic en,
                      input logic [3:0] ec, input logic etc, input logic edn, input logic ern);
      exp_t e;
      #1;
      load_i     = ld;
      load_val_i = v;
      en_i       = en;
      dir_i      = d_dir;
      mode_i     = d_mode;
      prescale_i = d_pre;
      @(posedge clk);
      e.c  = ec;
      e.tc = etc;
      e.dn = edn;
      e.rn = ern;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("count", int'(count_o), int'(e.c));
         chk("tc", int'(tc_o), int'(e.tc));
         chk("done", int'(done_o), int'(e.dn));
         chk("running", int'(running_o), int'(e.rn));
      end
   end

   initial begin
      int m;
      #1;
      chk("rst_count", int'(count_o), 0);
      chk("rst_tc", int'(tc_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_running", int'(running_o), 1);
      #11;
      reset = 1'b0;

      // 1: load 6, up, auto, prescale 0
      d_dir = DIR_UP; d_mode = MODE_AUTO; d_pre = 4'd0;
      cyc(1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         m = k % 10;
         if (m == 0) cyc(1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
         else        cyc(1'b0, 4'd0, 1'b1, 4'(6 + m), 1'b0, 1'b0, 1'b1);
      end

      // 2: load 3, down, auto
      d_dir = DIR_DOWN;
      cyc(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         m = k % 4;
         if (m == 0) cyc(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
         else        cyc(1'b0, 4'd0, 1'b1, 4'(3 - m), 1'b0, 1'b0, 1'b1);
      end

      // 3: load D, up, one-shot; halt survives a mode change; reload restarts
      d_dir = DIR_UP; d_mode = MODE_ONESHOT;
      cyc(1'b1, 4'hD, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
      d_mode = MODE_AUTO;
      for (int k = 0; k < 3; k++) cyc(1'b0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);

      // 4: prescale 2, freeze with en low mid-period
      d_pre = 4'd2;
      cyc(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) cyc(1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);

      // 5: load collides with the terminal tick
      d_pre = 4'd0;
      cyc(1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
      for (int k = 5; k <= 15; k++) cyc(1'b0, 4'd0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);

      // 6: async reset between edges at count B
      cyc(1'b0, 4'd0, 1'b0, 4'hB, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("async_count", int'(count_o), 0);
      chk("async_tc", int'(tc_o), 0);
      chk("async_done", int'(done_o), 0);
      chk("async_running", int'(running_o), 1);
      #1 reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 16) cyc(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
         else         cyc(1'b0, 4'd0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b1);
      end
      cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);

      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
